// File: rtl/nios_system_4a_cpu_cpu_mult_seq.sv
// Sequential 32x32 multiplier controller for the Nios CPU.
// Drives an external 16x16 partial-product cell over two issue passes,
// then combines the partial products into the low word (mul) or the
// unsigned / mixed / signed high word (mulxuu / mulxsu / mulxss).
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high.  valid, once raised, keeps its payload stable until that
// edge.  req_ready is high only in IDLE.  rsp_valid is high for the whole
// RSP state, and rsp_result holds until rsp_valid && rsp_ready.
module nios_system_4a_cpu_cpu_mult_seq (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic [31:0] mc_src1,
   output logic [31:0] mc_src2,
   output logic        mc_en,
   input  logic [31:0] mc_p1,
   input  logic [31:0] mc_p2,
   input  logic [31:0] mc_p3,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE1 = 3'd1,
      S_CAP1   = 3'd2,
      S_ISSUE2 = 3'd3,
      S_CAP2   = 3'd4,
      S_RSP    = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [1:0]  r_op;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_ll;
   logic [31:0] r_lh;
   logic [31:0] r_hl;
   logic [31:0] r_hh;
   logic [31:0] r_result;

   logic [31:0] w_ll;
   logic [31:0] w_lh;
   logic [31:0] w_hl;
   logic [31:0] w_hh;
   logic [32:0] w_mid;
   logic [63:0] w_u;
   logic [31:0] w_corr_a;
   logic [31:0] w_corr_b;
   logic [31:0] w_result;
   logic        w_accept;
   logic        w_load_result;

   assign w_accept      = req_valid && (r_state == S_IDLE);
   assign w_load_result = ((r_state == S_CAP1) && (r_op == 2'b00)) ||
                          (r_state == S_CAP2);

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next-state logic: mul skips the second (high-half) pass.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (req_valid) w_next = S_ISSUE1;
         S_ISSUE1: w_next = S_CAP1;
         S_CAP1:   w_next = (r_op == 2'b00) ? S_RSP : S_ISSUE2;
         S_ISSUE2: w_next = S_CAP2;
         S_CAP2:   w_next = S_RSP;
         S_RSP:    if (rsp_ready) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Outputs decoded from the state register; cell is driven only while issuing.
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mc_en     = 1'b0;
      mc_src1   = 32'h0;
      mc_src2   = 32'h0;
      dbg_state = r_state;
      case (r_state)
         S_IDLE:   req_ready = 1'b1;
         S_ISSUE1: begin
            mc_en   = 1'b1;
            mc_src1 = r_a;
            mc_src2 = r_b;
         end
         S_ISSUE2: begin
            mc_en   = 1'b1;
            mc_src1 = {16'h0, r_a[31:16]};
            mc_src2 = {16'h0, r_b[31:16]};
         end
         S_RSP:    rsp_valid = 1'b1;
         default:  ;
      endcase
   end

   // Partial products are read straight from the cell in the capture state,
   // so the result can be registered on the same edge that enters RSP.
   always_comb begin
      w_ll     = (r_state == S_CAP1) ? mc_p1 : r_ll;
      w_lh     = (r_state == S_CAP1) ? mc_p2 : r_lh;
      w_hl     = (r_state == S_CAP1) ? mc_p3 : r_hl;
      w_hh     = (r_state == S_CAP2) ? mc_p1 : r_hh;
      w_mid    = {1'b0, w_lh} + {1'b0, w_hl};
      w_u      = {w_hh, 32'h0} + {15'h0, w_mid, 16'h0} + {32'h0, w_ll};
      w_corr_a = r_a[31] ? r_b : 32'h0;
      w_corr_b = r_b[31] ? r_a : 32'h0;
      case (r_op)
         2'b00:   w_result = w_u[31:0];
         2'b01:   w_result = w_u[63:32];
         2'b10:   w_result = w_u[63:32] - w_corr_a;
         default: w_result = w_u[63:32] - w_corr_a - w_corr_b;
      endcase
   end

   // Operand capture, partial-product capture and result register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_op     <= 2'b00;
         r_a      <= 32'h0;
         r_b      <= 32'h0;
         r_ll     <= 32'h0;
         r_lh     <= 32'h0;
         r_hl     <= 32'h0;
         r_hh     <= 32'h0;
         r_result <= 32'h0;
      end else begin
         if (w_accept) begin
            r_op <= req_op;
            r_a  <= req_a;
            r_b  <= req_b;
         end
         if (r_state == S_CAP1) begin
            r_ll <= mc_p1;
            r_lh <= mc_p2;
            r_hl <= mc_p3;
         end
         if (r_state == S_CAP2) r_hh <= mc_p1;
         if (w_load_result)     r_result <= w_result;
      end
   end

   assign rsp_result = r_result;

endmodule

// File: tb/tb_nios_system_4a_cpu_cpu_mult_seq.sv
// Bench for the sequential multiplier controller: models the partial-product
// cell, keeps a queue of expected results, and checks issue timing, latency,
// back-pressure and asynchronous reset behaviour.
module tb_nios_system_4a_cpu_cpu_mult_seq;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic [31:0] mc_src1;
   logic [31:0] mc_src2;
   logic        mc_en;
   logic [31:0] mc_p1;
   logic [31:0] mc_p2;
   logic [31:0] mc_p3;
   logic [2:0]  dbg_state;

   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit reached");
   end

   nios_system_4a_cpu_cpu_mult_seq dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .mc_src1    (mc_src1),
      .mc_src2    (mc_src2),
      .mc_en      (mc_en),
      .mc_p1      (mc_p1),
      .mc_p2      (mc_p2),
      .mc_p3      (mc_p3),
      .dbg_state  (dbg_state)
   );

   // Multiplier cell: one-cycle latency, holds while mc_en is low.
   always @(posedge clk) begin
      if (mc_en) begin
         mc_p1 <= {16'h0, mc_src1[15:0]}  * {16'h0, mc_src2[15:0]};
         mc_p2 <= {16'h0, mc_src1[15:0]}  * {16'h0, mc_src2[31:16]};
         mc_p3 <= {16'h0, mc_src1[31:16]} * {16'h0, mc_src2[15:0]};
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          t;
   } txn_t;

   logic [31:0] exp_q[$];
   txn_t        meta_q[$];
   txn_t        cur;
   int          n_checks = 0;
   int          n_errors = 0;
   int          last_t   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: full 64-bit product with the operands extended per op.
   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic [63:0]        p;
      sa = (op[1]) ? {{32{a[31]}}, a} : {32'h0, a};
      sb = (op == 2'b11) ? {{32{b[31]}}, b} : {32'h0, b};
      p  = sa * sb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // Monitor: issue timing, latency, RSP stability, result compare.
   logic        seen_valid  = 1'b0;
   logic        prev_valid  = 1'b0;
   logic        prev_hs     = 1'b0;
   logic [31:0] prev_result = 32'h0;

   always @(negedge clk) begin
      if (!reset_n) begin
         exp_q.delete();
         meta_q.delete();
         seen_valid = 1'b0;
         prev_valid = 1'b0;
         prev_hs    = 1'b0;
      end else begin
         if (meta_q.size() > 0) begin
            cur = meta_q[0];
            if (cyc == cur.t + 1) begin
               chk("issue1_en",   32'(mc_en), 32'd1);
               chk("issue1_src1", mc_src1, cur.a);
               chk("issue1_src2", mc_src2, cur.b);
            end
            if (cyc == cur.t + 2) chk("cap1_en", 32'(mc_en), 32'd0);
            if (cur.op != 2'b00 && cyc == cur.t + 3) begin
               chk("issue2_en",   32'(mc_en), 32'd1);
               chk("issue2_src1", mc_src1, {16'h0, cur.a[31:16]});
               chk("issue2_src2", mc_src2, {16'h0, cur.b[31:16]});
            end
            if (rsp_valid && !seen_valid) begin
               chk("latency", 32'(cyc - cur.t), (cur.op == 2'b00) ? 32'd3 : 32'd5);
               seen_valid = 1'b1;
            end
         end
         if (rsp_valid && prev_valid && !prev_hs) chk("rsp_stable", rsp_result, prev_result);
         if (rsp_valid) chk("rsp_req_ready", 32'(req_ready), 32'd0);
         prev_hs     = rsp_valid && rsp_ready;
         prev_valid  = rsp_valid;
         prev_result = rsp_result;
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
               chk("result", rsp_result, exp_q.pop_front());
               void'(meta_q.pop_front());
               seen_valid = 1'b0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp, input bit chk_empty);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         chk("accept_timeout", 32'(req_ready), 32'd1);
      end else begin
         if (chk_empty) chk("accept_after_rsp", 32'(exp_q.size()), 32'd0);
         exp_q.push_back(exp);
         meta_q.push_back('{op, a, b, cyc});
         last_t = cyc;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
      @(posedge clk);
      #1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_valid = 1'b1;
      wait_accept(op, a, b, exp, 1'b0);
   endtask

   task automatic drain();
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
      chk("drain", 32'(exp_q.size()), 32'd0);
   endtask

   // Directed vectors: {op, a, b, expected}
   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F};
      vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[2] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[3] = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000};
      vecs[4] = '{2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[5] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[6] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
      vecs[7] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
      vecs[8] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      bit          got;

      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_a     = 32'h0;
      req_b     = 32'h0;
      rsp_ready = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_rsp_valid",  32'(rsp_valid), 32'd0);
      chk("rst_rsp_result", rsp_result, 32'h0);
      chk("rst_mc_en",      32'(mc_en), 32'd0);
      chk("rst_mc_src1",    mc_src1, 32'h0);
      chk("rst_mc_src2",    mc_src2, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);

      // Directed corner products
      foreach (vecs[i]) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      drain();

      // Random operands and ops
      for (int i = 0; i < 20; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         if (i % 5 == 0) a[31] = 1'b1;
         if (i % 7 == 0) b[31] = 1'b1;
         send(op, a, b, ref_mul(op, a, b));
      end
      drain();

      // Back-pressure: response held for 3 cycles while a new request waits
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      send(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, ref_mul(2'b01, 32'h1234_5678, 32'h9ABC_DEF0));
      req_op    = 2'b00;
      req_a     = 32'd7;
      req_b     = 32'd9;
      req_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got = 1'b1;
            break;
         end
      end
      chk("bp_rsp_seen", 32'(got), 32'd1);
      for (int k = 0; k < 3; k++) begin
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_result",    rsp_result, 32'h0B00_EA4E);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         chk("bp_mc_en",     32'(mc_en), 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      wait_accept(2'b00, 32'd7, 32'd9, 32'd63, 1'b1);
      drain();

      // Reset during ISSUE2 abandons the operation
      send(2'b11, 32'h8765_4321, 32'hF00D_CAFE, ref_mul(2'b11, 32'h8765_4321, 32'hF00D_CAFE));
      for (int k = 0; k < 10 && cyc != last_t + 3; k++) @(negedge clk);
      chk("iss2_reached", 32'(mc_en), 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_mc_en",      32'(mc_en), 32'd0);
      chk("arst_mc_src1",    mc_src1, 32'h0);
      chk("arst_mc_src2",    mc_src2, 32'h0);
      chk("arst_rsp_valid",  32'(rsp_valid), 32'd0);
      chk("arst_rsp_result", rsp_result, 32'h0);
      chk("arst_req_ready",  32'(req_ready), 32'd1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("arst_ready_after", 32'(req_ready), 32'd1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("arst_no_rsp", 32'(rsp_valid), 32'd0);
      end
      send(2'b00, 32'd3, 32'd5, 32'h0000_000F);
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
